// File: rtl/mdu_controller.sv
// Multiply/divide sequencer for the E stage: owns HI/LO and holds busy high
// for the modelled mult/div latency, committing results only on the last cycle.
module mdu_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          busy_q, busy_d;

  function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; INT_MIN / -1 is pinned so it never reaches the divider.
  function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Next-state: accept in IDLE, count down in RUN, commit on the final cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = mul_res(A, B, op == OP_MULT);
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              {pend_hi_d, pend_lo_d} = div_res(A, B, op == OP_DIV);
              pend_wr_d = (B != 32'd0);
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Directed self-checking bench for mdu_controller (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_err = 0;

  mdu_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, check busy/unchanged HI,LO for n cycles, then the committed values.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hi_hold"}, HI, pre_hi);
      chk({tag, "_lo_hold"}, LO, pre_lo);
      tick();
    end
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu0", 3'd4, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);

    start = 1'b1; op = 3'd5; A = 32'h1234_5678;
    tick();
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'hFFFF_FFFD);
    op = 3'd6; A = 32'hCAFE_BABE;
    tick();
    start = 1'b0; op = 3'd0;
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_hi", HI, 32'h1234_5678);
    chk("mtlo_lo", LO, 32'hCAFE_BABE);

    run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h1234_5678, 32'hCAFE_BABE,
           32'd0, 32'h8000_0000);
    run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd0, 32'h8000_0000, 32'd2, 32'd14);
    run_op("divneg", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd2, 32'd14, 32'd1, 32'hFFFF_FFFD);

    // start during RUN and on the completing edge are both ignored
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd5;
    tick();
    op = 3'd6; A = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; op = 3'd0;
    chk("ign_busy", {31'd0, busy}, 32'd1);
    chk("ign_lo_hold", LO, 32'hFFFF_FFFD);
    tick();
    tick();
    tick();
    chk("ign_busy5", {31'd0, busy}, 32'd1);
    start = 1'b1; op = 3'd5; A = 32'h1111_1111;
    tick();
    start = 1'b0; op = 3'd0;
    chk("ign_fall", {31'd0, busy}, 32'd0);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd15);
    start = 1'b1; op = 3'd6; A = 32'hABCD_0123;
    tick();
    start = 1'b0; op = 3'd0;
    chk("b2b_busy", {31'd0, busy}, 32'd0);
    chk("b2b_hi", HI, 32'd0);
    chk("b2b_lo", LO, 32'hABCD_0123);

    // reset in the 4th busy cycle of a divide
    start = 1'b1; op = 3'd4; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0; op = 3'd0;
    tick();
    tick();
    tick();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_hi", HI, 32'd0);
    chk("mid_lo", LO, 32'd0);
    repeat (12) tick();
    chk("mid_after_busy", {31'd0, busy}, 32'd0);
    chk("mid_after_hi", HI, 32'd0);
    chk("mid_after_lo", LO, 32'd0);

    // reset wins over start
    reset = 1'b1; start = 1'b1; op = 3'd5; A = 32'h5555_5555;
    tick();
    reset = 1'b0; start = 1'b0; op = 3'd0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    chk("rst_start_hi", HI, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
